// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates CPU (c) and debug (d) ports, splits
// unaligned accesses into two word cycles and aligns/extends load results.
//
// state | meaning
// IDLE  | waiting for a request; winner latched on the edge leaving IDLE
// ACC1  | first (or only) word cycle at the addressed word
// ACC2  | second word cycle of a split access at address + 4
// DONE  | ack pulse and load result for the granted port
module dmem_access_ctrl #(
  parameter int FIXED_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_wr,
  input  logic [1:0]  c_size,
  input  logic        c_signed,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_we,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t      state_q, state_nx;
  logic        rr_q;
  logic        wr_q, sgn_q, gnt_d_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q;

  logic        take, pick_d;
  logic        cur_wr, cur_sgn, cur_gnt_d;
  logic [1:0]  cur_size, o_c;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  n_c;
  logic        split_c;
  logic [3:0]  base;
  logic [7:0]  lane8;
  logic [63:0] sh_w;

  logic        c_ack_nx, d_ack_nx, busy_nx;
  logic [3:0]  we_nx;
  logic [31:0] addr_nx, wdata_nx, lo_nx, hi_nx, rd_w, ext;

  // Outputs are registered, so everything is computed from the fields that
  // will be valid in the next state: live inputs on the grant edge, latched after.
  always_comb begin
    take      = (state_q == IDLE) && (c_req || d_req);
    pick_d    = d_req && (!c_req || ((FIXED_PRIO == 0) && rr_q));
    cur_wr    = wr_q;
    cur_sgn   = sgn_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_gnt_d = gnt_d_q;
    if (take) begin
      cur_wr    = pick_d ? d_wr     : c_wr;
      cur_sgn   = pick_d ? d_signed : c_signed;
      cur_size  = pick_d ? d_size   : c_size;
      cur_addr  = pick_d ? d_addr   : c_addr;
      cur_wdata = pick_d ? d_wdata  : c_wdata;
      cur_gnt_d = pick_d;
    end
    o_c = cur_addr[1:0];
    case (cur_size)
      2'd0:    n_c = 3'd1;
      2'd1:    n_c = 3'd2;
      default: n_c = 3'd4;
    endcase
    split_c = ({2'b00, o_c} + {1'b0, n_c}) > 4'd4;
    case (n_c)
      3'd1:    base = 4'b0001;
      3'd2:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lane8 = {4'b0000, base} << o_c;
    sh_w  = {32'h0, cur_wdata} << {o_c, 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: if (take) state_nx = ACC1;
      ACC1: state_nx = split_c ? ACC2 : DONE;
      ACC2: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    we_nx    = 4'b0000;
    addr_nx  = m_addr;
    wdata_nx = m_wdata;
    lo_nx    = lo_q;
    hi_nx    = hi_q;
    if (state_q == ACC1 && !wr_q) begin
      lo_nx = m_rdata;
      hi_nx = 32'h0;
    end
    if (state_q == ACC2 && !wr_q) hi_nx = m_rdata;
    if (state_nx == ACC1) begin
      addr_nx  = {cur_addr[31:2], 2'b00};
      wdata_nx = sh_w[31:0];
      we_nx    = cur_wr ? lane8[3:0] : 4'b0000;
    end else if (state_nx == ACC2) begin
      addr_nx  = m_addr + 32'd4;
      wdata_nx = sh_w[63:32];
      we_nx    = cur_wr ? lane8[7:4] : 4'b0000;
    end
    rd_w = 32'({hi_nx, lo_nx} >> {o_c, 3'b000});
    case (n_c)
      3'd1:    ext = {{24{cur_sgn & rd_w[7]}},  rd_w[7:0]};
      3'd2:    ext = {{16{cur_sgn & rd_w[15]}}, rd_w[15:0]};
      default: ext = rd_w;
    endcase
    c_ack_nx = (state_nx == DONE) && !cur_gnt_d;
    d_ack_nx = (state_nx == DONE) &&  cur_gnt_d;
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      gnt_d_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      c_rdata <= 32'h0;
      d_rdata <= 32'h0;
      busy    <= 1'b0;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
      m_we    <= 4'b0000;
    end else begin
      if (take) begin
        wr_q    <= cur_wr;
        sgn_q   <= cur_sgn;
        gnt_d_q <= cur_gnt_d;
        size_q  <= cur_size;
        addr_q  <= cur_addr;
        wdata_q <= cur_wdata;
        if (c_req && d_req) rr_q <= !pick_d;
      end
      lo_q    <= lo_nx;
      hi_q    <= hi_nx;
      c_ack   <= c_ack_nx;
      d_ack   <= d_ack_nx;
      c_rdata <= c_ack_nx ? ext : 32'h0;
      d_rdata <= d_ack_nx ? ext : 32'h0;
      busy    <= busy_nx;
      m_addr  <= addr_nx;
      m_wdata <= wdata_nx;
      m_we    <= we_nx;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-lane memory model, vector table, ack
// scoreboard, plus reset-mid-access and round-robin conflict sequences.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_wr, c_signed, d_req, d_wr, d_signed;
  logic [1:0]  c_size, d_size;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, d_ack, busy;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_we;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  we1;
    logic [3:0]  we2;
    logic [31:0] wd1;
    logic [31:0] wd2;
  } vec_t;

  typedef struct packed {
    logic        port;
    logic        ld;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];

  dmem_access_ctrl #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_wr(c_wr), .c_size(c_size), .c_signed(c_signed),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .busy(busy), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[11:2]];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (m_we[i]) mem[m_addr[11:2]][8*i +: 8] = m_wdata[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (c_ack || d_ack)) begin
      chk("one_ack", {31'b0, c_ack & d_ack}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
        if (e.ld) chk("rdata", d_ack ? d_rdata : c_rdata, e.rdata);
      end
    end
  end

  task automatic drive(input logic port, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      d_req = 1'b1; d_wr = wr; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = 1'b1; c_wr = wr; c_size = size; c_signed = sgn; c_addr = addr; c_wdata = wdata;
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    while (busy) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    logic [31:0] a1, a2, d1, d2, base_a;
    logic [3:0]  w1, w2;
    exp_t e;
    lat = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0; w1 = 0; w2 = 0;
    base_a = {v.addr[31:2], 2'b00};
    wait_idle();
    e.port = v.port; e.ld = !v.wr; e.rdata = v.rdata;
    sbq.push_back(e);
    drive(v.port, v.wr, v.size, v.sgn, v.addr, v.wdata);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k == 1) begin a1 = m_addr; w1 = m_we; d1 = m_wdata; end
      if (k == 2) begin a2 = m_addr; w2 = m_we; d2 = m_wdata; end
      if (c_ack || d_ack) begin lat = k; break; end
      @(posedge clk);
    end
    c_req = 1'b0; d_req = 1'b0;
    chk("ack_latency", lat, v.lat);
    chk("acc1_addr", a1, base_a);
    chk("acc1_we", {28'b0, w1}, {28'b0, v.we1});
    chk("acc2_we", {28'b0, w2}, {28'b0, v.we2});
    if (v.wr) chk("acc1_wdata", d1, v.wd1);
    if (v.lat == 3) begin
      chk("acc2_addr", a2, base_a + 32'd4);
      if (v.wr) chk("acc2_wdata", d2, v.wd2);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[16];
    exp_t e;
    int ack_n, last;
    logic prt[4];

    // port wr size sgn addr wdata rdata lat we1 we2 wd1 wd2
    vt[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 4'b1111, 4'b0000, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'hFFFFFFDE, 2, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h000000DE, 2, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'hFFFFBEEF, 2, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h0000DEAD, 2, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h101, 32'h11223344, 32'h0, 3, 4'b1110, 4'b0001, 32'h22334400, 32'h00000011};
    vt[6]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11223344, 3, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h102, 32'hFFFFFF5A, 32'h0, 2, 4'b0100, 4'b0000, 32'hFF5A0000, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h225A44EF, 2, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h108, 32'hCAFEF00D, 32'h0, 2, 4'b1111, 4'b0000, 32'hCAFEF00D, 32'h0};
    vt[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 32'hCAFEF00D, 2, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[11] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0, 32'h00007F80, 3, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[12] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h1FF, 32'h0, 32'h00007F80, 3, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, 32'h0, 3, 4'b1100, 4'b0011, 32'hC3D40000, 32'h0000A1B2};
    vt[14] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'hA1B2C3D4, 3, 4'b0, 4'b0, 32'h0, 32'h0};
    vt[15] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 32'hFFFFFFEF, 2, 4'b0, 4'b0, 32'h0, 32'h0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h1FC >> 2] = 32'h80123456;
    mem[32'h200 >> 2] = 32'hABCDEF7F;

    rst = 1'b1;
    c_req = 0; c_wr = 0; c_size = 0; c_signed = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_signed = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",    {31'b0, busy},  32'd0);
    chk("rst_c_ack",   {31'b0, c_ack}, 32'd0);
    chk("rst_d_ack",   {31'b0, d_ack}, 32'd0);
    chk("rst_m_we",    {28'b0, m_we},  32'd0);
    chk("rst_m_addr",  m_addr,  32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vt[i]);

    // Reset during ACC2 of a split halfword store.
    mem[32'h200 >> 2] = 32'h11111111;
    mem[32'h204 >> 2] = 32'h22222222;
    wait_idle();
    drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h203, 32'h0000BEEF);
    @(posedge clk); #1;
    chk("rstacc_acc1_we",    {28'b0, m_we}, {28'b0, 4'b1000});
    chk("rstacc_acc1_wdata", m_wdata, 32'hEF000000);
    @(posedge clk); #1;
    chk("rstacc_acc2_we",   {28'b0, m_we}, {28'b0, 4'b0001});
    chk("rstacc_acc2_addr", m_addr, 32'h204);
    #1 rst = 1'b1;
    #1;
    chk("rstacc_we_cleared", {28'b0, m_we}, 32'd0);
    chk("rstacc_busy",       {31'b0, busy}, 32'd0);
    c_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstacc_no_ack", {31'b0, c_ack | d_ack}, 32'd0);
    end
    chk("rstacc_word200", mem[32'h200 >> 2], 32'hEF111111);
    chk("rstacc_word204", mem[32'h204 >> 2], 32'h22222222);
    rst = 1'b0;

    // Continuous conflict: round-robin alternates c, d, c, d at 3 cycles per pass.
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.ld = 1'b1;
      e.rdata = i[0] ? 32'hCAFEF00D : 32'h225A44EF;
      sbq.push_back(e);
    end
    c_wr = 0; c_size = 2'd2; c_signed = 0; c_addr = 32'h100;
    d_wr = 0; d_size = 2'd2; d_signed = 0; d_addr = 32'h108;
    c_req = 1'b1; d_req = 1'b1;
    ack_n = 0; last = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (c_ack || d_ack) begin
        if (ack_n > 0) chk("rr_interval", cyc - last, 3);
        prt[ack_n] = d_ack;
        last = cyc;
        ack_n++;
        if (ack_n == 4) break;
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    chk("rr_ack_count", ack_n, 4);
    for (int i = 0; i < ack_n; i++) chk("rr_port", {31'b0, prt[i]}, {31'b0, i[0]});

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
